// File: rtl/exa_crosb_output_vc_arbiter.sv
// Per-output VC arbiter: packet-level grant hold plus per-output-VC credit counters.
// Define EXA_CROSB_OARB_STRICT_PRIO_EN for strict VC-level priority with per-level round-robin.
module exa_crosb_output_vc_arbiter #(
   parameter  int input_num  = 4,
   parameter  int prio_num   = 2,
   parameter  int vc_num     = 2,
   parameter  int fifo_depth = 8,
   localparam int NVC = prio_num * vc_num,
   localparam int IW  = (input_num > 1) ? $clog2(input_num) : 1,
   localparam int VW  = (NVC > 1) ? $clog2(NVC) : 1,
   localparam int CW  = $clog2(fifo_depth + 1)
) (
   input  logic                           clk,
   input  logic                           resetn,
   input  logic [input_num-1:0][NVC-1:0]  i_request,
   input  logic [input_num-1:0]           i_valid,
   input  logic [input_num-1:0]           i_last,
   input  logic [NVC-1:0]                 i_credit_return,
   output logic [input_num-1:0]           o_grant,
   output logic [IW-1:0]                  o_sel_input,
   output logic [VW-1:0]                  o_granted_vc,
   output logic                           o_ready,
   output logic [NVC-1:0]                 o_credit_avail,
   output logic                           o_credit_err
);

`ifdef EXA_CROSB_OARB_STRICT_PRIO_EN
   localparam int NPTR = prio_num;
`else
   localparam int NPTR = 1;
`endif

   typedef enum logic {IDLE, GRANTED} state_t;

   state_t                 state_q, state_d;
   logic [input_num-1:0]   grant_q, grant_d;
   logic [IW-1:0]          sel_q, sel_d;
   logic [VW-1:0]          vc_q, vc_d;
   logic [IW-1:0]          rr_q [NPTR];
   logic [IW-1:0]          rr_d [NPTR];
   logic [CW-1:0]          cnt_q [NVC];
   logic [CW-1:0]          cnt_d [NVC];
   logic [NVC-1:0]         avail_q;
   logic                   err_q, err_d;

   logic                   ready;
   logic                   accept;
   logic                   found;
   logic [IW-1:0]          win_i;
   logic [VW-1:0]          win_v;
   logic [input_num-1:0][NVC-1:0] elig;

   assign ready  = (state_q == GRANTED) && (cnt_q[vc_q] != '0);
   assign accept = ready && i_valid[sel_q];

   always_comb begin
      int idx;
      idx   = 0;
      found = 1'b0;
      win_i = '0;
      win_v = '0;
      for (int i = 0; i < input_num; i++)
         for (int v = 0; v < NVC; v++)
            elig[i][v] = i_request[i][v] && (cnt_q[v] != '0);
`ifdef EXA_CROSB_OARB_STRICT_PRIO_EN
      // Highest level first, then round-robin from that level's pointer.
      for (int l = prio_num - 1; l >= 0; l--)
         for (int k = 0; k < input_num; k++) begin
            idx = (int'(rr_q[l]) + k) % input_num;
            for (int j = 0; j < vc_num; j++)
               if (!found && elig[idx][l*vc_num+j]) begin
                  found = 1'b1;
                  win_i = IW'(idx);
                  win_v = VW'(l*vc_num+j);
               end
         end
`else
      for (int k = 0; k < input_num; k++) begin
         idx = (int'(rr_q[0]) + k) % input_num;
         for (int v = 0; v < NVC; v++)
            if (!found && elig[idx][v]) begin
               found = 1'b1;
               win_i = IW'(idx);
               win_v = VW'(v);
            end
      end
`endif
   end

   always_comb begin
      int p;
`ifdef EXA_CROSB_OARB_STRICT_PRIO_EN
      p = int'(vc_q) / vc_num;
`else
      p = 0;
`endif
      state_d = state_q;
      grant_d = grant_q;
      sel_d   = sel_q;
      vc_d    = vc_q;
      rr_d    = rr_q;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               state_d        = GRANTED;
               sel_d          = win_i;
               vc_d           = win_v;
               grant_d        = '0;
               grant_d[win_i] = 1'b1;
            end
         end
         GRANTED: begin
            if (accept && i_last[sel_q]) begin
               state_d = IDLE;
               grant_d = '0;
               rr_d[p] = (int'(sel_q) == input_num - 1) ? '0 : sel_q + IW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Simultaneous return and consume cancel; a return at full depth is an overflow.
   always_comb begin
      err_d = err_q;
      for (int v = 0; v < NVC; v++) begin
         cnt_d[v] = cnt_q[v];
         if (i_credit_return[v] && !(accept && vc_q == VW'(v))) begin
            if (cnt_q[v] == CW'(fifo_depth))
               err_d = 1'b1;
            else
               cnt_d[v] = cnt_q[v] + CW'(1);
         end else if (!i_credit_return[v] && accept && vc_q == VW'(v)) begin
            cnt_d[v] = cnt_q[v] - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= IDLE;
         grant_q <= '0;
         sel_q   <= '0;
         vc_q    <= '0;
         avail_q <= '1;
         err_q   <= 1'b0;
         for (int p = 0; p < NPTR; p++) rr_q[p] <= '0;
         for (int v = 0; v < NVC; v++) cnt_q[v] <= CW'(fifo_depth);
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         sel_q   <= sel_d;
         vc_q    <= vc_d;
         err_q   <= err_d;
         rr_q    <= rr_d;
         for (int v = 0; v < NVC; v++) begin
            cnt_q[v]   <= cnt_d[v];
            avail_q[v] <= (cnt_q[v] != '0);
         end
      end
   end

   assign o_grant        = grant_q;
   assign o_sel_input    = sel_q;
   assign o_granted_vc   = vc_q;
   assign o_ready        = ready;
   assign o_credit_avail = avail_q;
   assign o_credit_err   = err_q;

endmodule

// File: tb/tb_exa_crosb_output_vc_arbiter.sv
// Directed bench for exa_crosb_output_vc_arbiter (default parameters).
// Priority expectations follow EXA_CROSB_OARB_STRICT_PRIO_EN.
module tb_exa_crosb_output_vc_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            resetn;
   logic [3:0][3:0] req;
   logic [3:0]      vld;
   logic [3:0]      lst;
   logic [3:0]      cret;
   logic [3:0]      grant;
   logic [1:0]      sel;
   logic [1:0]      gvc;
   logic            rdy;
   logic [3:0]      avail;
   logic            err;

   int total = 0;
   int bad   = 0;

   exa_crosb_output_vc_arbiter #(
      .input_num(4), .prio_num(2), .vc_num(2), .fifo_depth(8)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .i_request(req),
      .i_valid(vld),
      .i_last(lst),
      .i_credit_return(cret),
      .o_grant(grant),
      .o_sel_input(sel),
      .o_granted_vc(gvc),
      .o_ready(rdy),
      .o_credit_avail(avail),
      .o_credit_err(err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic clr();
      req  = '0;
      vld  = '0;
      lst  = '0;
      cret = '0;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      clr();
      step(2);
      resetn = 1'b1;
   endtask

   logic [3:0] exp_g [7];

   initial begin
      exp_g = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b0001};
      do_reset();
      chk("rst_grant", grant, 4'b0000);
      chk("rst_ready", rdy, 1'b0);
      chk("rst_avail", avail, 4'hF);
      chk("rst_err", err, 1'b0);
      chk("rst_sel", sel, 2'd0);
      chk("rst_vc", gvc, 2'd0);

      // single 3-flit packet, input 2 on VC1
      req[2] = 4'b0010;
      vld[2] = 1'b1;
      step();
      chk("s_grant", grant, 4'b0100);
      chk("s_sel", sel, 2'd2);
      chk("s_vc", gvc, 2'd1);
      chk("s_ready", rdy, 1'b1);
      step(2);
      chk("s_hold", grant, 4'b0100);
      lst[2] = 1'b1;
      step();
      chk("s_end_grant", grant, 4'b0000);
      chk("s_end_ready", rdy, 1'b0);
      chk("s_cnt1", dut.cnt_q[1], 5);
      clr();
      cret[1] = 1'b1;
      step(3);
      cret = '0;
      chk("s_cnt1_back", dut.cnt_q[1], 8);
      chk("s_err", err, 1'b0);

      // priority between VC0 and VC2 requests
      do_reset();
      req[0] = 4'b0001;
      req[3] = 4'b0100;
      vld = 4'b1001;
      lst = 4'b1001;
      step();
`ifdef EXA_CROSB_OARB_STRICT_PRIO_EN
      chk("p_grant", grant, 4'b1000);
      chk("p_vc", gvc, 2'd2);
`else
      chk("p_grant", grant, 4'b0001);
      chk("p_vc", gvc, 2'd0);
`endif
      req = '0;
      step();
      chk("p_end", grant, 4'b0000);
      clr();

      // round-robin among inputs 0..2 on VC2, 1-flit packets
      do_reset();
      for (int i = 0; i < 3; i++) req[i] = 4'b0100;
      vld = 4'b0111;
      lst = 4'b0111;
      for (int k = 0; k < 7; k++) begin
         step();
         chk($sformatf("rr_%0d", k), grant, exp_g[k]);
      end
      req = '0;
      step();
      chk("rr_cnt2", dut.cnt_q[2], 4);
      clr();

      // credit stall: 10-flit packet on VC3 with depth 8
      do_reset();
      req[1] = 4'b1000;
      vld[1] = 1'b1;
      step();
      chk("c_grant", grant, 4'b0010);
      chk("c_vc", gvc, 2'd3);
      step(8);
      chk("c_ready0", rdy, 1'b0);
      chk("c_cnt3", dut.cnt_q[3], 0);
      step();
      chk("c_avail", avail, 4'b0111);
      chk("c_stall_grant", grant, 4'b0010);
      cret[3] = 1'b1;
      step();
      cret = '0;
      chk("c_ready1", rdy, 1'b1);
      step();
      chk("c_ready2", rdy, 1'b0);
      cret[3] = 1'b1;
      step();
      cret = '0;
      chk("c_ready3", rdy, 1'b1);
      lst[1] = 1'b1;
      step();
      chk("c_end", grant, 4'b0000);
      clr();

      // simultaneous return/accept, then overflow
      do_reset();
      req[0] = 4'b0010;
      vld[0] = 1'b1;
      step();
      step(6);
      chk("o_cnt_a", dut.cnt_q[1], 2);
      cret[1] = 1'b1;
      step();
      cret = '0;
      chk("o_cnt_b", dut.cnt_q[1], 2);
      lst[0] = 1'b1;
      step();
      clr();
      chk("o_cnt_c", dut.cnt_q[1], 1);
      cret[1] = 1'b1;
      step(7);
      chk("o_cnt_full", dut.cnt_q[1], 8);
      chk("o_err_pre", err, 1'b0);
      step();
      cret = '0;
      chk("o_cnt_sat", dut.cnt_q[1], 8);
      chk("o_err_set", err, 1'b1);
      step(3);
      chk("o_err_sticky", err, 1'b1);

      // reset in the middle of a packet
      req[3] = 4'b0001;
      vld[3] = 1'b1;
      step();
      chk("r_grant", grant, 4'b1000);
      step();
      resetn = 1'b0;
      step();
      chk("r_grant0", grant, 4'b0000);
      chk("r_ready0", rdy, 1'b0);
      chk("r_avail", avail, 4'hF);
      chk("r_err", err, 1'b0);
      chk("r_cnt0", dut.cnt_q[0], 8);
      resetn = 1'b1;
      clr();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
